// File: rtl/ms_duration_timer.sv
// -----------------------------------------------------------------------------
// ms_duration_timer
//
// Millisecond countdown timer driven by the 1 ms tick from the LFSR timebase.
// A start request loads a duration in ms; every tick then takes one off the
// count until it expires. Expiry raises a sticky done flag that stays up
// until it is acknowledged. The count can be paused, restarted or aborted.
// The braille trainer control FSMs use it for hold times, character gaps and
// answer timeouts.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   tick       1 ms strobe, one clk cycle wide
//   start      single-cycle request: load duration and begin counting
//   duration   ms to count; sampled only on the start cycle
//   pause      level; while high the count is frozen and ticks are ignored
//   abort      single-cycle request: cancel and return to idle
//   ack        single-cycle clear of done
//   busy       high while counting or paused
//   done       high after expiry until ack, start or abort
//   remaining  ms left; frozen while paused; 0 when idle or done
//
// All outputs come straight from flops. No input reaches an output without
// passing through a register.
// -----------------------------------------------------------------------------
module ms_duration_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic [WIDTH-1:0] duration,
  input  logic             pause,
  input  logic             abort,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state logic. Priority: abort > start > ack/pause > tick.
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    remaining_d = remaining_q;

    if (abort) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else if (start) begin
      // Restart is allowed from any state. A tick on the start cycle is not
      // counted, and a zero duration expires immediately without ever
      // showing busy.
      if (duration != '0) begin
        state_d     = RUN;
        remaining_d = duration;
      end else begin
        state_d     = DONE;
        remaining_d = '0;
      end
    end else begin
      unique case (state_q)
        IDLE: ;
        RUN: begin
          if (pause) begin
            // A tick arriving with pause is dropped.
            state_d = HOLD;
          end else if (tick) begin
            // Expire at 1 rather than 0 so the count never wraps.
            if (remaining_q == WIDTH'(1)) begin
              state_d     = DONE;
              remaining_d = '0;
            end else begin
              remaining_d = remaining_q - WIDTH'(1);
            end
          end
        end
        HOLD: begin
          // A tick coincident with leaving HOLD is ignored as well.
          if (!pause) state_d = RUN;
        end
        DONE: begin
          if (ack) state_d = IDLE;
        end
        default: begin
          state_d     = IDLE;
          remaining_d = '0;
        end
      endcase
    end

    // Flags decoded from the next state, so busy falls and done rises on the
    // same edge.
    busy_d = (state_d == RUN) || (state_d == HOLD);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_ms_duration_timer.sv
// -----------------------------------------------------------------------------
// tb_ms_duration_timer
//
// Self-checking bench for ms_duration_timer. Each scenario task drives one
// cycle of inputs at a time and pushes the outputs it expects after the next
// rising edge into a scoreboard queue; the cycle driver pops that entry once
// the edge has happened and compares it against busy, done and remaining.
// -----------------------------------------------------------------------------
module tb_ms_duration_timer;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         tick;
  logic         start;
  logic [W-1:0] duration;
  logic         pause;
  logic         abort;
  logic         ack;
  logic         busy;
  logic         done;
  logic [W-1:0] remaining;

  typedef struct {
    string        name;
    logic         busy;
    logic         done;
    logic [W-1:0] rem;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  ms_duration_timer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .start     (start),
    .duration  (duration),
    .pause     (pause),
    .abort     (abort),
    .ack       (ack),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, record the expectation, let one rising edge
  // pass, then pop the expectation and compare 1 ns after the edge.
  task automatic cyc(input string nm, input logic t, input logic s,
                     input logic [W-1:0] d, input logic p, input logic a,
                     input logic k, input logic eb, input logic ed,
                     input logic [W-1:0] er);
    exp_t e;
    tick     = t;
    start    = s;
    duration = d;
    pause    = p;
    abort    = a;
    ack      = k;
    sb.push_back('{nm, eb, ed, er});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      n_tests++;
      if (busy !== e.busy) begin
        n_fail++;
        $display("FAIL %s busy: got %b want %b", e.name, busy, e.busy);
      end
      n_tests++;
      if (done !== e.done) begin
        n_fail++;
        $display("FAIL %s done: got %b want %b", e.name, done, e.done);
      end
      n_tests++;
      if (remaining !== e.rem) begin
        n_fail++;
        $display("FAIL %s remaining: got %0d want %0d", e.name, remaining, e.rem);
      end
    end
  endtask

  // n cycles with no requests; outputs must stay at the given values.
  task automatic quiet(input string nm, input int n, input logic p,
                       input logic eb, input logic ed, input logic [W-1:0] er);
    for (int i = 0; i < n; i++) cyc(nm, 1'b0, 1'b0, '0, p, 1'b0, 1'b0, eb, ed, er);
  endtask

  task automatic test_reset;
    exp_t e;
    rst = 1'b0;
    quiet("reset_state", 3, 1'b0, 1'b0, 1'b0, '0);
    #3 rst = 1'b1;   // release well away from any edge
    cyc("idle_tick", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cyc("idle_ack_pause", 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc("rst_start100", 1'b0, 1'b1, 16'd100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd100);
    for (int i = 1; i <= 40; i++)
      cyc("rst_tick", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(100 - i));
    tick = 1'b0;
    // Asynchronous reset between edges: outputs clear with no clock edge.
    #2 rst = 1'b0;
    sb.push_back('{"async_reset", 1'b0, 1'b0, '0});
    #1;
    e = sb.pop_front();
    n_tests++;
    if (busy !== e.busy || done !== e.done || remaining !== e.rem) begin
      n_fail++;
      $display("FAIL %s: got busy=%b done=%b rem=%0d want busy=%b done=%b rem=%0d",
               e.name, busy, done, remaining, e.busy, e.done, e.rem);
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_basic_count;
    cyc("basic_start", 1'b0, 1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5);
    for (int i = 4; i >= 0; i--) begin
      quiet("basic_wait", 9, 1'b0, 1'b1, 1'b0, W'(i + 1));
      if (i == 0)
        cyc("basic_expire", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      else
        cyc("basic_tick", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(i));
    end
    quiet("basic_done_hold", 4, 1'b0, 1'b0, 1'b1, '0);
    cyc("done_ignores_tick_pause", 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    cyc("basic_ack", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc("basic_ack_held", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_pause;
    cyc("pause_start", 1'b0, 1'b1, 16'd10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd10);
    for (int i = 1; i <= 3; i++)
      cyc("pause_pre_tick", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(10 - i));
    cyc("pause_tick_dropped", 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd7);
    for (int i = 0; i < 5; i++)
      cyc("pause_hold_tick", 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd7);
    cyc("unpause_tick_ignored", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd7);
    for (int i = 6; i >= 1; i--)
      cyc("pause_post_tick", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(i));
    cyc("pause_expire", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    cyc("pause_ack", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_restart_zero;
    cyc("rs_start20", 1'b0, 1'b1, 16'd20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd20);
    for (int i = 1; i <= 4; i++)
      cyc("rs_tick", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(20 - i));
    cyc("rs_restart3", 1'b0, 1'b1, 16'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3);
    cyc("rs_tick2", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
    cyc("rs_tick1", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
    cyc("rs_expire", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    cyc("rs_ack", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc("zero_start", 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    quiet("zero_done_hold", 2, 1'b0, 1'b0, 1'b1, '0);
    cyc("zero_ack", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_priority;
    cyc("pri_start50", 1'b0, 1'b1, 16'd50, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd50);
    cyc("pri_start_abort", 1'b0, 1'b1, 16'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    cyc("pri_start2", 1'b0, 1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
    cyc("pri_tick", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
    cyc("pri_expire", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    cyc("pri_start_ack", 1'b0, 1'b1, 16'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd9);
    cyc("pri_tick_start", 1'b1, 1'b1, 16'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4);
    cyc("pri_next_tick", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3);
    cyc("pri_abort_run", 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_abort;
    cyc("ab_start1", 1'b0, 1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
    cyc("ab_expire", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    cyc("ab_abort_done", 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    cyc("ab_start_paused", 1'b0, 1'b1, 16'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5);
    cyc("ab_hold", 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5);
    cyc("ab_abort_hold", 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    cyc("ab_idle_after", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cyc("ab_restart1", 1'b0, 1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
    cyc("ab_final_expire", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    cyc("ab_final_ack", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rst      = 1'b0;
    tick     = 1'b0;
    start    = 1'b0;
    duration = '0;
    pause    = 1'b0;
    abort    = 1'b0;
    ack      = 1'b0;
    test_reset();
    test_basic_count();
    test_pause();
    test_restart_zero();
    test_priority();
    test_abort();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
